// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: word array serving CPU fetch/LD/STR,
// a host preload port, and a post-halt result dump port.
module cpu_mem_responder #(
  parameter int                   ADDR_SIZE = 12,
  parameter int                   WIDTH     = 32,
  parameter logic [ADDR_SIZE-1:0] DUMP_BASE = '0,
  parameter int                   DUMP_LEN  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_rw,
  input  logic [WIDTH-1:0]     mem_datain,
  output logic [WIDTH-1:0]     mem_data_out,
  input  logic                 halt,
  input  logic                 load_en,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ADDR_SIZE-1:0] dump_addr,
  output logic [WIDTH-1:0]     dump_data,
  output logic                 dump_done,
  output logic [1:0]           dbg_state
);

  localparam int                 DEPTH     = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] LAST_BEAT = (ADDR_SIZE+1)'(DUMP_LEN - 1);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    LOAD  = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [WIDTH-1:0]   mem [DEPTH];
  state_t             state;
  state_t             next_state;
  logic [ADDR_SIZE:0] count;
  logic               dump_fire;
  logic               dump_entry;
  logic               cpu_we;
  logic               ld_we;

  // Handshakes (ld_* and dump_*): a word transfers on a posedge where valid and
  // ready are both high; the producer holds its word stable until that edge.
  assign dump_fire  = dump_valid && dump_ready;
  assign dump_entry = (state != DUMP) && (next_state == DUMP);
  assign cpu_we     = (state == SERVE) && mem_rw;
  assign ld_we      = ld_valid && ld_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SERVE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SERVE: begin
        if (load_en)   next_state = LOAD;
        else if (halt) next_state = DUMP;
      end
      LOAD: begin
        if (!load_en) next_state = SERVE;
      end
      DUMP: begin
        if (dump_fire && (count == LAST_BEAT)) next_state = DONE;
      end
      DONE:    next_state = DONE;
      default: next_state = SERVE;
    endcase
  end

  // Handshake flags are decoded straight from the state register, so they are
  // glitch-free and drop the instant reset clears the state.
  always_comb begin
    ld_ready   = (state == LOAD);
    dump_valid = (state == DUMP);
    dump_done  = (state == DONE);
    dbg_state  = state;
  end

  // The array is deliberately left out of reset so a partial preload survives.
  always_ff @(posedge clk) begin
    if (cpu_we) mem[mem_addr] <= mem_datain;
    if (ld_we)  mem[ld_addr]  <= ld_data;
  end

  // Reading on the falling edge gives the CPU a stable word by the next posedge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_out <= '0;
    end else begin
      mem_data_out <= mem[mem_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dump_addr <= DUMP_BASE;
      count     <= '0;
    end else if (dump_entry) begin
      dump_addr <= DUMP_BASE;
      count     <= '0;
    end else if (dump_fire) begin
      dump_addr <= dump_addr + 1'b1;
      count     <= count + 1'b1;
    end
  end

  assign dump_data = mem[dump_addr];

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: table-driven CPU accesses plus hand-written
// load, dump, backpressure and reset sequences, checked against queues.
module tb_cpu_mem_responder;

  localparam int AW = 12;
  localparam int W  = 32;
  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic          clk;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic          mem_rw;
  logic [W-1:0]  mem_datain;
  logic [W-1:0]  mem_data_out;
  logic          halt;
  logic          load_en;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [W-1:0]  dump_data;
  logic          dump_done;
  logic [1:0]    dbg_state;

  cpu_mem_responder #(
    .ADDR_SIZE(AW),
    .WIDTH    (W),
    .DUMP_BASE(12'hFFE),
    .DUMP_LEN (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rw      (mem_rw),
    .mem_datain  (mem_datain),
    .mem_data_out(mem_data_out),
    .halt        (halt),
    .load_en     (load_en),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_done   (dump_done),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [W-1:0]  data;
  } vec_t;

  vec_t vecs[10];

  // Driver: one CPU access per cycle; reads are checked at the following negedge.
  task automatic cpu_access(input logic [AW-1:0] addr, input logic rw,
                            input logic [W-1:0] data, input string name);
    @(posedge clk); #1;
    mem_addr   = addr;
    mem_rw     = rw;
    mem_datain = data;
    if (!rw) exp_q.push_back(data);
    @(negedge clk); #1;
    if (!rw) chk(name, mem_data_out, exp_q.pop_front());
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1;
    mem_rw = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rnd_data[12];
    int  beats;
    bit  done_seen;

    vecs[0] = '{12'h010, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{12'h010, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{12'h000, 1'b0, 32'h2000_1001};
    vecs[3] = '{12'h001, 1'b0, 32'h9000_0000};
    vecs[4] = '{12'hFFE, 1'b1, 32'hCAFE_0001};
    vecs[5] = '{12'hFFF, 1'b1, 32'hCAFE_0002};
    vecs[6] = '{12'hFFE, 1'b0, 32'hCAFE_0001};
    vecs[7] = '{12'h020, 1'b1, 32'hA5A5_5A5A};
    vecs[8] = '{12'h020, 1'b0, 32'hA5A5_5A5A};
    vecs[9] = '{12'hFFF, 1'b0, 32'hCAFE_0002};

    reset = 1'b0; mem_addr = '0; mem_rw = 1'b0; mem_datain = '0;
    halt = 1'b0; load_en = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", mem_data_out, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_addr", dump_addr, 12'hFFE);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_state", dbg_state, S_SERVE);

    // Host preload of a two-word program
    reset = 1'b1;
    load_en = 1'b1;
    @(posedge clk); #1;
    chk("load_state", dbg_state, S_LOAD);
    chk("load_ready0", ld_ready, 1);
    ld_valid = 1'b1; ld_addr = 12'h000; ld_data = 32'h2000_1001;
    @(posedge clk); #1;
    chk("load_ready1", ld_ready, 1);
    ld_addr = 12'h001; ld_data = 32'h9000_0000;
    @(posedge clk); #1;
    ld_valid = 1'b0; load_en = 1'b0; mem_addr = 12'h000;
    @(posedge clk); #1;
    chk("load_exit_state", dbg_state, S_SERVE);
    chk("load_exit_ready", ld_ready, 0);
    @(negedge clk); #1;
    chk("fetch_addr0", mem_data_out, 32'h2000_1001);

    // Table-driven CPU writes/reads
    foreach (vecs[i]) cpu_access(vecs[i].addr, vecs[i].rw, vecs[i].data, $sformatf("vec%0d", i));

    // Random write-then-read pairs
    for (int i = 0; i < 12; i++) begin
      rnd_data[i] = $urandom_range(32'hFFFF_FFFF, 0);
      cpu_access(12'h100 + 12'(i), 1'b1, rnd_data[i], "rnd_wr");
    end
    for (int i = 0; i < 12; i++) cpu_access(12'h100 + 12'(i), 1'b0, rnd_data[i], $sformatf("rnd_rd%0d", i));

    // load_en beats halt; CPU write inside LOAD is dropped
    @(posedge clk); #1;
    mem_rw = 1'b0; load_en = 1'b1; halt = 1'b1;
    @(posedge clk); #1;
    chk("prio_state", dbg_state, S_LOAD);
    chk("prio_ld_ready", ld_ready, 1);
    chk("prio_no_dump", dump_valid, 0);
    halt = 1'b0; mem_rw = 1'b1; mem_addr = 12'h010; mem_datain = 32'h1234_5678;
    @(posedge clk); #1;
    chk("load_hold_state", dbg_state, S_LOAD);
    mem_rw = 1'b0; load_en = 1'b0;
    @(posedge clk); #1;
    chk("load_back_serve", dbg_state, S_SERVE);
    cpu_access(12'h010, 1'b0, 32'hDEAD_BEEF, "load_wr_ignored");

    // Dump with wrap and a 3-cycle stall
    exp_addr_q = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    exp_q      = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h2000_1001, 32'h9000_0000};
    halt = 1'b1;
    beats = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      @(posedge clk); #1;
      dump_ready = !(cyc >= 2 && cyc <= 4);
      @(negedge clk); #1;
      if (dump_done) begin
        done_seen = 1'b1;
      end else if (dump_valid) begin
        if (exp_addr_q.size() == 0) begin
          chk("dump_extra_beat", 1, 0);
        end else begin
          chk($sformatf("dump_addr_c%0d", cyc), dump_addr, exp_addr_q[0]);
          chk($sformatf("dump_data_c%0d", cyc), dump_data, exp_q[0]);
          if (dump_ready) begin
            void'(exp_addr_q.pop_front());
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
    end
    chk("dump_done_seen", done_seen, 1);
    chk("dump_beats", beats, 4);
    chk("dump_q_empty", exp_q.size(), 0);
    chk("done_valid_low", dump_valid, 0);
    halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_held", dbg_state, S_DONE);
    chk("done_flag_held", dump_done, 1);

    // Reset mid-dump, then restart from DUMP_BASE
    reset = 1'b0;
    #1;
    chk("rst2_state", dbg_state, S_SERVE);
    @(posedge clk); #1;
    reset = 1'b1; halt = 1'b1; dump_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk($sformatf("re_valid%0d", b), dump_valid, 1);
      chk($sformatf("re_addr%0d", b), dump_addr, 12'hFFE + 12'(b));
    end
    @(posedge clk); #1;
    chk("mid_addr", dump_addr, 12'h000);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", dump_valid, 0);
    chk("mid_rst_state", dbg_state, S_SERVE);
    chk("mid_rst_addr", dump_addr, 12'hFFE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("restart_valid", dump_valid, 1);
    chk("restart_addr", dump_addr, 12'hFFE);
    chk("restart_data", dump_data, 32'hCAFE_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
